// File: rtl/counter_link_if.sv
// Byte-level host link: TX byte valid/ready toward the host, single-cycle RX command byte from it.
interface counter_link_if;
    logic [7:0] oTxData;
    logic       oTxValid;
    logic       iTxReady;
    logic [7:0] iRxData;
    logic       iRxValid;

    modport master (output oTxData, output oTxValid, input iTxReady, input iRxData, input iRxValid);
    modport slave  (input oTxData, input oTxValid, output iTxReady, output iRxData, output iRxValid);
endinterface

// File: rtl/counter_link.sv
// Frames latched counts as {hdr, count LSB-first} for the host and decodes host command bytes; COUNTER_LINK_RETX_EN adds ack-timeout resend.
// Latency: header presented the cycle after a channel becomes eligible; command strobes rise the cycle after the RX byte.
// Backpressure: each TX byte is held stable until iTxReady; RX bytes are never stalled.
module counter_link #(
    parameter int pWIDTH       = 40,
    parameter int pPULSE       = 4,
    parameter int pRETX_CYCLES = 1000000
) (
    input  logic           iCLK,
    input  logic           iRST_N,
    input  logic           iRdy1,
    input  logic           iRdy2,
    input  logic [31:0]    i1Lo,
    input  logic [31:0]    i1Hi,
    input  logic [31:0]    i2Lo,
    input  logic [31:0]    i2Hi,
    output logic           oResetLatch1,
    output logic           oResetLatch2,
    output logic           oLatch1,
    output logic           oLatch2,
    output logic           oBadCmd,
    counter_link_if.master link
);

    localparam int NBYTES = pWIDTH / 8;
    localparam int PW     = $clog2(pPULSE + 1);

    generate
        if ((pWIDTH % 8) != 0 || pWIDTH < 33 || pWIDTH > 64 || pPULSE < 1 || pRETX_CYCLES < 1) begin : g_bad_params
            $error("counter_link: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HDR, DATA, WACK} state_t;

    state_t             state_q, state_d;
    logic               chan_q, chan_d;     // 0 = register 1, 1 = register 2
    logic               last_q, last_d;
    logic               armed1_q, armed1_d;
    logic               armed2_q, armed2_d;
    logic [pWIDTH-1:0]  shift_q, shift_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [3:0][PW-1:0] pulse_q, pulse_d;   // indexed by command code 0..3
    logic               bad_q, bad_d;
    logic               tx_hs, ack1, ack2, busy, elig1, elig2, pick;

`ifdef COUNTER_LINK_RETX_EN
    localparam int TW = $clog2(pRETX_CYCLES + 1);
    logic [TW-1:0]      timer_q, timer_d;
`endif

    assign link.oTxValid = (state_q == HDR) || (state_q == DATA);
    assign link.oTxData  = (state_q == HDR)  ? {7'd0, chan_q} :
                           (state_q == DATA) ? shift_q[7:0]   : 8'h00;
    assign oResetLatch1  = (pulse_q[0] != '0);
    assign oResetLatch2  = (pulse_q[1] != '0);
    assign oLatch1       = (pulse_q[2] != '0);
    assign oLatch2       = (pulse_q[3] != '0);
    assign oBadCmd       = bad_q;

    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        last_d   = last_q;
        armed1_d = armed1_q;
        armed2_d = armed2_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        pulse_d  = pulse_q;
        bad_d    = bad_q;
`ifdef COUNTER_LINK_RETX_EN
        timer_d  = '0;
`endif
        tx_hs = link.oTxValid && link.iTxReady;
        ack1  = link.iRxValid && (link.iRxData == 8'h00);
        ack2  = link.iRxValid && (link.iRxData == 8'h01);
        busy  = (state_q != IDLE);
        elig1 = iRdy1 && armed1_q;
        elig2 = iRdy2 && armed2_q;
        // Round-robin: register 2 wins unless register 1 is eligible and register 2 went last
        pick  = !(elig1 && (!elig2 || last_q));

        for (int i = 0; i < 4; i++) begin
            if (pulse_q[i] != '0) pulse_d[i] = pulse_q[i] - PW'(1);
        end
        if (link.iRxValid) begin
            if (link.iRxData[7:2] == 6'd0) pulse_d[link.iRxData[1:0]] = PW'(pPULSE);
            else                           bad_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (elig1 || elig2) begin
                    chan_d  = pick;
                    last_d  = pick;
                    shift_d = pick ? pWIDTH'({i2Hi, i2Lo}) : pWIDTH'({i1Hi, i1Lo});
                    if (pick) armed2_d = 1'b0;
                    else      armed1_d = 1'b0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (tx_hs) begin
                    cnt_d   = 4'(NBYTES);
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tx_hs) begin
                    shift_d = shift_q >> 8;
                    cnt_d   = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = WACK;
                end
            end
            WACK: begin
                if ((ack1 && !chan_q) || (ack2 && chan_q)) begin
                    state_d = IDLE;
                end
`ifdef COUNTER_LINK_RETX_EN
                else begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TW'(pRETX_CYCLES - 1)) begin
                        state_d = IDLE;
                        if (chan_q) armed2_d = 1'b1;
                        else        armed1_d = 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A low ready only re-arms a channel that is not mid-frame or awaiting its ack
        if (!iRdy1 && !(busy && !chan_q)) armed1_d = 1'b1;
        if (!iRdy2 && !(busy &&  chan_q)) armed2_d = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            chan_q   <= 1'b0;
            last_q   <= 1'b1;
            armed1_q <= 1'b1;
            armed2_q <= 1'b1;
            shift_q  <= '0;
            cnt_q    <= '0;
            pulse_q  <= '0;
            bad_q    <= 1'b0;
`ifdef COUNTER_LINK_RETX_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            chan_q   <= chan_d;
            last_q   <= last_d;
            armed1_q <= armed1_d;
            armed2_q <= armed2_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            bad_q    <= bad_d;
`ifdef COUNTER_LINK_RETX_EN
            timer_q  <= timer_d;
`endif
        end
    end

endmodule

// File: doc/counter_link.md
# counter_link

Byte-stream front end for the two-register latch counter. It serialises each latched count into a 6-byte frame for the host UART/USB transmitter. It also decodes single-byte host commands into the counter's latch-reset and software-latch strobes. It sits between the counter block (register outputs and ready flags) and the byte-level host link (TX/RX byte handshakes).

## Interface
- pWIDTH, 40, counter width in bits; multiple of 8, range 33..64
- pPULSE, 4, width in cycles of every command-generated strobe
- pRETX_CYCLES, 1000000, ack timeout in cycles (used only with retransmit compiled in)
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iRdy1 / iRdy2  in  1  register 1 / register 2 holds a latched value
- i1Lo / i2Lo  in  32  low word of register 1 / register 2
- i1Hi / i2Hi  in  32  high word of register 1 / register 2; bits above pWIDTH-33 ignored
- oResetLatch1 / oResetLatch2  out  1  latch-reset strobe to counter
- oLatch1 / oLatch2  out  1  software latch strobe to counter
- oTxData  out  8  byte to host
- oTxValid  out  1  oTxData valid
- iTxReady  in  1  transmitter accepts byte this cycle
- iRxData  in  8  byte from host
- iRxValid  in  1  single-cycle, iRxData valid
- oBadCmd  out  1  sticky: unrecognised command byte received; cleared only by reset

## Operation
- Frame format: header 0x00 for register 1 or 0x01 for register 2, then pWIDTH/8 count bytes, LSB first. Default frame is 6 bytes.
- Per-channel armed flag:
  - Reset value 1.
  - Cleared when that channel's frame starts.
  - Set again only after a cycle with iRdyN low is sampled while the channel is not in a frame or waiting for an ack.
  - This prevents re-sending a value the counter still holds after its reset strobe.
- A channel is eligible when iRdyN=1 and armedN=1.
- FSM:
  - IDLE: if any channel is eligible, snapshot that channel's {Hi,Lo} into the shift register. Go to HDR.
  - HDR: drive the header byte. On handshake, go to DATA.
  - DATA: drive the shift-register LSB byte. On handshake, shift right by 8 and decrement the byte counter. After the last byte, go to WACK.
  - WACK: wait for the matching ack, then go to IDLE.
- Arbitration: round-robin. When both channels are eligible in IDLE, serve the channel not served last. After reset, channel 1 goes first.
- Command decode applies in any FSM state:
  - 0x00: pulse oResetLatch1. If in WACK for channel 1, go to IDLE.
  - 0x01: pulse oResetLatch2. If in WACK for channel 2, go to IDLE.
  - 0x02: pulse oLatch1.
  - 0x03: pulse oLatch2.
  - Any other value: set oBadCmd; no other effect.
- An ack for the channel not in WACK still pulses its reset strobe and does not change FSM state.
- A command arriving while the same strobe is already active restarts its pulse counter (pulse extends).
- If iRdyN falls mid-frame, the frame completes with the snapshot value. The snapshot is never re-sampled within a frame.

## Timing
- Reset values: all strobes 0, oTxValid 0, oTxData 0x00, oBadCmd 0, FSM IDLE, armed1=armed2=1, last-served = channel 2.
- Frame start latency: eligible in cycle N, so the snapshot is taken at edge N. oTxValid=1 with the header from cycle N+1.
- Once oTxValid is asserted, it and oTxData stay stable until a cycle with iTxReady=1. The next byte is presented in the following cycle.
- Back-to-back TX: with iTxReady held at 1, a 6-byte frame occupies 6 consecutive cycles.
- Command strobe: iRxValid in cycle N drives the strobe high for cycles N+1..N+pPULSE.
- WACK exit is on the edge of the ack byte's iRxValid cycle. A new frame can start in cycle N+1 if the other channel is eligible.
- Reset asserted mid-frame: oTxValid drops immediately (asynchronously), the partial frame is abandoned, and all state returns to reset values.

## Configuration
- COUNTER_LINK_RETX_EN defined:
  - In WACK, a timer counts cycles.
  - At pRETX_CYCLES without a matching ack, the FSM returns to IDLE and the waiting channel is re-armed.
  - The next frame for that channel re-snapshots the inputs, so the same latched value is resent.
  - Timer width is $clog2(pRETX_CYCLES+1).
- Not defined: WACK waits indefinitely for the ack, and no timer logic exists.

## Test plan
- Reset, then iRdy1=1, i1Lo=0x89ABCDEF, i1Hi=0x12, iTxReady=1 -> bytes 00 EF CD AB 89 12 in 6 consecutive cycles. Then oTxValid=0 in WACK.
- Ack byte 0x00 -> oResetLatch1 high exactly 4 cycles starting next cycle. iRdy1 held high -> no resend until iRdy1 seen low and then high again.
- iRdy1=iRdy2=1 simultaneously with both acked between frames -> frame order ch1, ch2, ch1, ch2.
- RX 0x03 then 0x7F -> oLatch2 pulses 4 cycles and oBadCmd=1 sticky. FSM unaffected.
- iTxReady toggled 1 cycle in 3 -> every byte held stable until accepted, frame content unchanged. iRdy1 dropped after the header -> remaining bytes are the snapshot value.
- With COUNTER_LINK_RETX_EN and pRETX_CYCLES=16, no ack -> identical frame resent 16 cycles after the last byte. iRST_N pulsed mid-frame -> oTxValid=0 immediately, then a fresh full frame after release.
